// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV64M multiply/divide unit.
// The op encodings follow funct3 so the decoder can pass it straight through.
package muldiv_pkg;
   localparam int XLEN = 64;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} muldiv_state_t;
endpackage

// File: rtl/muldiv_unit.sv
// Iterative 64-bit multiply/divide. One op in flight, fixed 66-cycle latency.
// Multiply (shift-add) and restoring divide share one 128-bit shift register:
// the upper half is accumulator/remainder, the lower half multiplier/quotient.
// Operands are converted to magnitudes on accept; signs are reapplied in FIX.
module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out
);

   muldiv_state_t     state_q, state_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic [4:0]        rd_q, rd_d;
   logic              neg_a_q, neg_a_d;
   logic              neg_b_q, neg_b_d;
   logic [XLEN-1:0]   a_orig_q, a_orig_d;
   logic [XLEN-1:0]   b_abs_q, b_abs_d;
   logic [2*XLEN-1:0] sr_q, sr_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [4:0]        rd_out_q, rd_out_d;

   logic              a_signed, b_signed;
   logic [XLEN:0]     add_sum, rem_sh, sub_diff;
   logic [2*XLEN-1:0] mul_step, div_step, prod;
   logic [XLEN-1:0]   quo, rem, fix_res;

   assign a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   assign b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);

   // One iteration of each algorithm; the FSM picks which one to commit.
   always_comb begin
      add_sum  = {1'b0, sr_q[2*XLEN-1:XLEN]} + (sr_q[0] ? {1'b0, b_abs_q} : {(XLEN+1){1'b0}});
      mul_step = {add_sum, sr_q[XLEN-1:1]};
      rem_sh   = {sr_q[2*XLEN-1:XLEN], sr_q[XLEN-1]};
      sub_diff = rem_sh - {1'b0, b_abs_q};
      if (sub_diff[XLEN])
         div_step = {rem_sh[XLEN-1:0], sr_q[XLEN-2:0], 1'b0};
      else
         div_step = {sub_diff[XLEN-1:0], sr_q[XLEN-2:0], 1'b1};
   end

   // Sign correction and output select; divide-by-zero overrides the datapath.
   always_comb begin
      prod = (neg_a_q ^ neg_b_q) ? -sr_q : sr_q;
      quo  = (neg_a_q ^ neg_b_q) ? -sr_q[XLEN-1:0] : sr_q[XLEN-1:0];
      rem  = neg_a_q ? -sr_q[2*XLEN-1:XLEN] : sr_q[2*XLEN-1:XLEN];
      case (op_q)
         OP_MUL:                       fix_res = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              fix_res = (b_abs_q == '0) ? '1 : quo;
         default:                      fix_res = (b_abs_q == '0) ? a_orig_q : rem;
      endcase
   end

   // Next-state and datapath updates for IDLE -> CALC -> FIX -> DONE.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      rd_d     = rd_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      a_orig_d = a_orig_q;
      b_abs_d  = b_abs_q;
      sr_d     = sr_q;
      result_d = result_q;
      rd_out_d = rd_out_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d     = op;
               rd_d     = rd_in;
               neg_a_d  = a_signed & operand_a[XLEN-1];
               neg_b_d  = b_signed & operand_b[XLEN-1];
               a_orig_d = operand_a;
               b_abs_d  = (b_signed & operand_b[XLEN-1]) ? -operand_b : operand_b;
               sr_d     = {{XLEN{1'b0}}, (a_signed & operand_a[XLEN-1]) ? -operand_a : operand_a};
               cnt_d    = '0;
               state_d  = CALC;
            end
         end
         CALC: begin
            sr_d  = op_q[2] ? div_step : mul_step;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd63) state_d = FIX;
         end
         FIX: begin
            result_d = fix_res;
            rd_out_d = rd_q;
            state_d  = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         rd_q     <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         a_orig_q <= '0;
         b_abs_q  <= '0;
         sr_q     <= '0;
         result_q <= '0;
         rd_out_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         a_orig_q <= a_orig_d;
         b_abs_q  <= b_abs_d;
         sr_q     <= sr_d;
         result_q <= result_d;
         rd_out_q <= rd_out_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE);
   assign result = result_q;
   assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results are queued at issue
// and popped when done fires. Inputs driven and outputs sampled on negedge.
module tb_muldiv_unit;
   logic        clk = 1'b0;
   logic        reset, start;
   logic [2:0]  op;
   logic [63:0] operand_a, operand_b;
   logic [4:0]  rd_in;
   logic        busy, done;
   logic [63:0] result;
   logic [4:0]  rd_out;

   typedef struct {
      logic [63:0] res;
      logic [4:0]  rd;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   muldiv_unit dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in),
      .busy(busy), .done(done), .result(result), .rd_out(rd_out)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference RV64M semantics.
   function automatic logic [63:0] model_res(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
      logic [127:0]       p;
      logic signed [63:0] as_, bs_;
      as_ = a;
      bs_ = b;
      case (o)
         3'd0: begin p = {64'b0, a} * {64'b0, b}; return p[63:0]; end
         3'd1: begin p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); return p[127:64]; end
         3'd2: begin p = $signed({{64{a[63]}}, a}) * $signed({64'b0, b}); return p[127:64]; end
         3'd3: begin p = {64'b0, a} * {64'b0, b}; return p[127:64]; end
         3'd4: begin
            if (b == 0) return '1;
            if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
            return as_ / bs_;
         end
         3'd5: return (b == 0) ? '1 : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 64'h8000_0000_0000_0000 && b == '1) return 64'd0;
            return as_ % bs_;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Called on a negedge with the unit idle; returns on the negedge after DONE.
   // intrude drives extra starts sampled at edges k+10, k+65 and k+66.
   task automatic do_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rd, input logic [63:0] exp, input bit intrude);
      int   n;
      exp_t e;
      op = o; operand_a = a; operand_b = b; rd_in = rd; start = 1'b1;
      sb_q.push_back('{exp, rd});
      @(negedge clk);
      start = 1'b0;
      operand_a = {$urandom, $urandom};
      operand_b = {$urandom, $urandom};
      rd_in = 5'($urandom);
      check_val("busy_after_accept", busy, 1);
      n = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
         start = intrude && (n == 9 || n == 64 || n == 65);
         if (start) begin
            op = 3'($urandom);
            operand_a = {$urandom, $urandom};
            operand_b = {$urandom, $urandom};
            rd_in = 5'($urandom);
         end
      end
      check_val("latency", n, 65);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_val("result", result, e.res);
         check_val("rd_out", rd_out, e.rd);
      end
      @(negedge clk);
      start = 1'b0;
      check_val("done_one_cycle", done, 0);
      check_val("busy_idle", busy, 0);
      check_val("result_hold", result, e.res);
   endtask

   initial begin
      int          dcnt;
      logic [2:0]  ro;
      logic [63:0] ra, rb;
      reset = 1'b1; start = 1'b0; op = '0; operand_a = '0; operand_b = '0; rd_in = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_result", result, 0);
      check_val("rst_rd_out", rd_out, 0);

      // reset and start together: start dropped
      reset = 1'b1; start = 1'b1; op = 3'd0; operand_a = 64'd2; operand_b = 64'd3; rd_in = 5'd4;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      check_val("rst_start_busy", busy, 0);

      do_op(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
      do_op(3'd3, '1, '1, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
      do_op(3'd1, '1, '1, 5'd2, 64'd0, 1'b0);
      do_op(3'd2, '1, '1, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      do_op(3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
      do_op(3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      do_op(3'd5, 64'd100, 64'd7, 5'd8, 64'd14, 1'b0);
      do_op(3'd7, 64'd100, 64'd7, 5'd0, 64'd2, 1'b0);
      do_op(3'd5, 64'd5, 64'd0, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      do_op(3'd4, 64'd5, 64'd0, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      do_op(3'd7, 64'd5, 64'd0, 5'd13, 64'd5, 1'b0);
      do_op(3'd6, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd14, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0);
      do_op(3'd4, 64'h8000_0000_0000_0000, '1, 5'd15, 64'h8000_0000_0000_0000, 1'b0);
      do_op(3'd6, 64'h8000_0000_0000_0000, '1, 5'd16, 64'd0, 1'b0);

      // starts while busy are ignored; the next one right after idle is taken
      do_op(3'd5, 64'd1000, 64'd3, 5'd9, 64'd333, 1'b1);
      do_op(3'd0, 64'd6, 64'd7, 5'd10, 64'd42, 1'b0);

      for (int i = 0; i < 10; i++) begin
         ro = 3'($urandom);
         ra = {$urandom, $urandom};
         rb = (i % 3 == 0) ? 64'($urandom_range(0, 20)) : {$urandom, $urandom};
         if (i % 4 == 1) rb = -rb;
         do_op(ro, ra, rb, 5'($urandom), model_res(ro, ra, rb), 1'b0);
      end

      // reset mid-CALC aborts the op without a done
      op = 3'd0; operand_a = 64'd9; operand_b = 64'd9; rd_in = 5'd20; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_val("abort_busy", busy, 0);
      check_val("abort_done", done, 0);
      check_val("abort_result", result, 0);
      check_val("abort_rd_out", rd_out, 0);
      dcnt = 0;
      repeat (80) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      check_val("abort_no_done", dcnt, 0);
      do_op(3'd0, 64'd3, 64'd4, 5'd21, 64'd12, 1'b0);

      check_val("sb_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
